// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_ctrl
//  Description : Byte-addressable data memory for the MEM stage. Handles
//                LB/LH/LW/LBU/LHU/SB/SH/SW with lane masking and extension,
//                a valid/ready request port, a fixed response latency, a
//                post-reset preload (word i := i) and access error flagging.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
    parameter int DEPTH_WORDS   = 256,
    parameter int LATENCY       = 1,
    parameter int PRELOAD_WORDS = 32
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int c_AW        = $clog2(DEPTH_WORDS);
    localparam int c_CW        = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam int c_CNT_INIT  = (LATENCY >= 2) ? LATENCY - 2 : 0;
    localparam int c_INIT_LAST = (PRELOAD_WORDS > 0) ? PRELOAD_WORDS - 1 : 0;

    localparam logic [1:0] c_S_INIT = 2'd0;
    localparam logic [1:0] c_S_IDLE = 2'd1;
    localparam logic [1:0] c_S_WAIT = 2'd2;
    localparam logic [1:0] c_S_RESP = 2'd3;

    logic [31:0]     r_mem [DEPTH_WORDS];
    logic [1:0]      r_state;
    logic [c_AW-1:0] r_init_ptr;
    logic [c_CW-1:0] r_cnt;
    logic [31:0]     r_hold_data;
    logic            r_hold_err;

    logic [c_AW-1:0] w_idx;
    logic [1:0]      w_lane;
    logic            w_oor;
    logic            w_mis;
    logic            w_err;
    logic            w_accept;
    logic [31:0]     w_rd_word;
    logic [31:0]     w_shifted;
    logic [31:0]     w_load;
    logic [31:0]     w_wdata_sh;
    logic [3:0]      w_be;

    assign w_idx     = req_addr[c_AW+1:2];
    assign w_lane    = req_addr[1:0];
    assign w_oor     = (req_addr >> (c_AW + 2)) != 32'd0;
    assign w_mis     = ((req_size == 2'b01) && req_addr[0]) ||
                       ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_err     = w_oor || w_mis || (req_size == 2'b11);
    assign w_accept  = req_valid && (r_state == c_S_IDLE);
    assign w_rd_word = r_mem[w_idx];
    // Halves are 2-byte aligned on good accesses, so a lane*8 shift serves both sizes
    assign w_shifted = w_rd_word >> {w_lane, 3'b000};

    // Lane extraction/extension for loads and lane placement for stores
    always_comb begin
        w_be       = 4'b0000;
        w_wdata_sh = 32'd0;
        w_load     = 32'd0;
        case (req_size)
            2'b00: begin
                w_be       = 4'b0001 << w_lane;
                w_wdata_sh = {24'd0, req_wdata[7:0]} << {w_lane, 3'b000};
                w_load     = req_unsigned ? {24'd0, w_shifted[7:0]}
                                          : {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            2'b01: begin
                w_be       = 4'b0011 << w_lane;
                w_wdata_sh = {16'd0, req_wdata[15:0]} << {w_lane, 3'b000};
                w_load     = req_unsigned ? {16'd0, w_shifted[15:0]}
                                          : {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            2'b10: begin
                w_be       = 4'b1111;
                w_wdata_sh = req_wdata;
                w_load     = w_rd_word;
            end
            default: begin
                w_be       = 4'b0000;
            end
        endcase
    end

    // Memory array: preload writes during INIT, masked store writes on accept
    always_ff @(posedge clock) begin
        if (!rst) begin
            if ((r_state == c_S_INIT) && (PRELOAD_WORDS > 0)) begin
                r_mem[r_init_ptr] <= 32'(r_init_ptr);
            end else if (w_accept && req_write && !w_err) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_be[b]) begin
                        r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                    end
                end
            end
        end
    end

    // Control FSM: preload sequencing, request acceptance and latency timing
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state     <= c_S_INIT;
            r_init_ptr  <= '0;
            r_cnt       <= '0;
            r_hold_data <= 32'd0;
            r_hold_err  <= 1'b0;
        end else begin
            case (r_state)
                c_S_INIT: begin
                    if ((PRELOAD_WORDS == 0) || (r_init_ptr == c_AW'(c_INIT_LAST))) begin
                        r_state <= c_S_IDLE;
                    end else begin
                        r_init_ptr <= r_init_ptr + 1'b1;
                    end
                end
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_hold_data <= (w_err || req_write) ? 32'd0 : w_load;
                        r_hold_err  <= w_err;
                        r_cnt       <= c_CW'(c_CNT_INIT);
                        r_state     <= (LATENCY == 1) ? c_S_RESP : c_S_WAIT;
                    end
                end
                c_S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= c_S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == c_S_IDLE);
    assign resp_valid = (r_state == c_S_RESP);
    assign resp_rdata = resp_valid ? r_hold_data : 32'd0;
    assign resp_err   = resp_valid && r_hold_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_ctrl
//  Description : Directed self-checking bench for data_mem_ctrl; one instance
//                at default parameters and one with LATENCY=3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst, req_valid, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        l3_rst, l3_valid, l3_write, l3_unsigned;
    logic [1:0]  l3_size;
    logic [31:0] l3_addr, l3_wdata;
    logic        l3_ready, l3_resp_valid, l3_resp_err;
    logic [31:0] l3_resp_rdata;

    int errors = 0;
    int checks = 0;

    data_mem_ctrl #(.DEPTH_WORDS(256), .LATENCY(1), .PRELOAD_WORDS(32)) u_dut (
        .clock(clock), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    data_mem_ctrl #(.DEPTH_WORDS(256), .LATENCY(3), .PRELOAD_WORDS(32)) u_dut_l3 (
        .clock(clock), .rst(l3_rst), .req_valid(l3_valid), .req_ready(l3_ready),
        .req_write(l3_write), .req_size(l3_size), .req_unsigned(l3_unsigned),
        .req_addr(l3_addr), .req_wdata(l3_wdata), .resp_valid(l3_resp_valid),
        .resp_rdata(l3_resp_rdata), .resp_err(l3_resp_err)
    );

    // One transaction on the LATENCY=1 instance; lat = negedges from accept to resp_valid
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic err, output int lat);
        int n;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout: req_ready=%0b required 1", req_ready);
        end
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clock);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!resp_valid && lat < 50);
        rdata = resp_rdata;
        err   = resp_err;
        if (!resp_valid) lat = -1;
    endtask

    task automatic test_reset;
        int cnt;
        rst = 1'b1; l3_rst = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b required 0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %0b required 0", resp_valid); end
        checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h required 00000000", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b required 0", resp_err); end
        rst = 1'b0; l3_rst = 1'b0;
        cnt = 0;
        while (req_ready !== 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clock);
        end
        checks++; if (cnt != 32) begin errors++; $display("FAIL init_cycles: got %0d required 32", cnt); end
    endtask

    task automatic test_preload_load;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b0, 2'b10, 1'b0, 32'h28, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'h0000000A) begin errors++; $display("FAIL lw_0x28_data: got %h required 0000000a", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_0x28_err: got %0b required 0", er); end
        checks++; if (lat != 1) begin errors++; $display("FAIL lw_0x28_latency: got %0d required 1", lat); end
        @(negedge clock);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL resp_pulse_width: resp_valid=%0b required 0", resp_valid); end
    endtask

    task automatic test_store_byte;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 2'b00, 1'b0, 32'h41, 32'h00000084, rd, er, lat);
        checks++; if (rd !== 32'd0 || er !== 1'b0 || lat != 1) begin errors++; $display("FAIL sb_resp: rdata=%h err=%0b lat=%0d required 0/0/1", rd, er, lat); end
        do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'h00008410) begin errors++; $display("FAIL sb_lw_0x40: got %h required 00008410", rd); end
        do_req(1'b0, 2'b00, 1'b0, 32'h41, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'hFFFFFF84) begin errors++; $display("FAIL lb_0x41: got %h required ffffff84", rd); end
        do_req(1'b0, 2'b00, 1'b1, 32'h41, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'h00000084) begin errors++; $display("FAIL lbu_0x41: got %h required 00000084", rd); end
    endtask

    task automatic test_store_half;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL sh_0x12_err: got %0b required 0", er); end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'hBEEF0004) begin errors++; $display("FAIL sh_lw_0x10: got %h required beef0004", rd); end
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh_0x12: got %h required ffffbeef", rd); end
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL lhu_0x12: got %h required 0000beef", rd); end
        do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'h00000004) begin errors++; $display("FAIL lhu_0x10: got %h required 00000004", rd); end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'd0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'd0 || lat != 1) begin errors++; $display("FAIL lw_misaligned: err=%0b rdata=%h lat=%0d required 1/0/1", er, rd, lat); end
        do_req(1'b1, 2'b01, 1'b0, 32'h07, 32'hFFFFFFFF, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL sh_misaligned: err=%0b required 1", er); end
        do_req(1'b0, 2'b10, 1'b0, 32'h04, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'h00000001 || er !== 1'b0) begin errors++; $display("FAIL word1_untouched: got %h err=%0b required 00000001/0", rd, er); end
        do_req(1'b0, 2'b11, 1'b0, 32'h08, 32'd0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL size_illegal: err=%0b rdata=%h required 1/0", er, rd); end
        do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'd0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL out_of_range: err=%0b rdata=%h required 1/0", er, rd); end
        do_req(1'b0, 2'b10, 1'b0, 32'h3FC, 32'd0, rd, er, lat);
        checks++; if (er !== 1'b0 || rd === 32'hxxxxxxxx) begin errors++; $display("FAIL last_word_in_range: err=%0b required 0", er); end
    endtask

    task automatic test_back_to_back;
        int n;
        int acc[$];
        int rsp[$];
        logic [31:0] first_rd;
        n = 0;
        first_rd = 32'd0;
        @(negedge clock);
        while (!l3_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        l3_valid = 1'b1; l3_write = 1'b0; l3_size = 2'b10; l3_unsigned = 1'b0;
        l3_addr = 32'h0C; l3_wdata = 32'd0;
        for (int k = 0; k < 13; k++) begin
            if (l3_valid && l3_ready) acc.push_back(k);
            if (l3_resp_valid) begin
                if (rsp.size() == 0) first_rd = l3_resp_rdata;
                rsp.push_back(k);
            end
            if (k < 12) @(negedge clock);
        end
        @(posedge clock);
        #1 l3_valid = 1'b0;
        repeat (6) @(negedge clock);
        checks++; if (acc.size() != 4) begin errors++; $display("FAIL b2b_accept_count: got %0d required 4", acc.size()); end
        checks++; if (rsp.size() != 3) begin errors++; $display("FAIL b2b_resp_count: got %0d required 3", rsp.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < acc.size()) begin
                checks++; if (acc[i] != 4 * i) begin errors++; $display("FAIL b2b_accept_spacing[%0d]: got %0d required %0d", i, acc[i], 4 * i); end
            end
            if (i < rsp.size() && i < acc.size()) begin
                checks++; if (rsp[i] != acc[i] + 3) begin errors++; $display("FAIL b2b_resp_latency[%0d]: got %0d required %0d", i, rsp[i] - acc[i], 3); end
            end
        end
        checks++; if (first_rd !== 32'h00000003) begin errors++; $display("FAIL b2b_rdata: got %h required 00000003", first_rd); end
    endtask

    task automatic test_reset_midflight;
        int n;
        int lat;
        logic saw;
        n = 0;
        saw = 1'b0;
        @(negedge clock);
        while (!l3_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        l3_valid = 1'b1; l3_write = 1'b0; l3_size = 2'b10; l3_addr = 32'h08;
        @(posedge clock);
        #1 l3_valid = 1'b0;
        @(negedge clock);
        if (l3_resp_valid) saw = 1'b1;
        l3_rst = 1'b1;
        @(posedge clock);
        @(negedge clock);
        l3_rst = 1'b0;
        n = 0;
        while (l3_ready !== 1'b1 && n < 100) begin
            if (l3_resp_valid) saw = 1'b1;
            n++;
            @(negedge clock);
        end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL midflight_resp_dropped: resp_valid seen=%0b required 0", saw); end
        checks++; if (n != 32) begin errors++; $display("FAIL midflight_init_rerun: got %0d cycles required 32", n); end
        l3_valid = 1'b1;
        @(posedge clock);
        #1 l3_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!l3_resp_valid && lat < 50);
        checks++; if (l3_resp_rdata !== 32'h00000002 || l3_resp_err !== 1'b0) begin errors++; $display("FAIL midflight_reload: got %h err=%0b required 00000002/0", l3_resp_rdata, l3_resp_err); end
        checks++; if (lat != 3) begin errors++; $display("FAIL midflight_latency: got %0d required 3", lat); end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b10;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        l3_rst = 1'b1; l3_valid = 1'b0; l3_write = 1'b0; l3_size = 2'b10;
        l3_unsigned = 1'b0; l3_addr = 32'd0; l3_wdata = 32'd0;
        test_reset();
        test_preload_load();
        test_store_byte();
        test_store_half();
        test_errors();
        test_back_to_back();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
